// File: rtl/arcade_pkg.sv
// Shared types and constants for the arcade ship-motion path.
// The phase width default is also used by sin_cos and Move_Ship.
package arcade_pkg;

    localparam int unsigned DEF_PHASE_BITS = 10;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rot_dir_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } rot_state_t;

    // Both buttons held at once cancel out.
    function automatic rot_dir_t decode_dir(input logic left, input logic right);
        if (left && !right) begin
            return LEFT;
        end else if (right && !left) begin
            return RIGHT;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer for one raw push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign level_o = sync_q[1];
    end else begin : g_filter
        localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;

        // Any cycle where the input agrees with the accepted level restarts the count.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level_o = level_q;
    end

endmodule

// File: rtl/ship_rotate_ctrl.sv
// Converts rotate-left/right buttons into the ship heading phase: first step on press,
// auto-repeat after a hold delay, with a rounded sprite index for the bitmap selector.
module ship_rotate_ctrl
    import arcade_pkg::*;
#(
    parameter int unsigned CLK_RATE        = 50_000_000,
    parameter int unsigned STEP_RATE       = 16,
    parameter int unsigned PHASE_BITS      = DEF_PHASE_BITS,
    parameter int unsigned STEP            = 8,
    parameter int unsigned HOLD_TICKS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned SPRITE_BITS     = 4,
    parameter int unsigned INIT_THETA      = 0
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   left_btn,
    input  logic                   right_btn,
    input  logic                   enable,
    output logic [PHASE_BITS-1:0]  theta,
    output logic                   theta_strobe,
    output logic [SPRITE_BITS-1:0] sprite_idx
);

    localparam int unsigned P     = CLK_RATE / STEP_RATE;
    localparam int unsigned PW    = (P < 2) ? 1 : $clog2(P);
    localparam int unsigned HW    = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS);
    localparam int unsigned SHIFT = PHASE_BITS - SPRITE_BITS;

    localparam logic [PHASE_BITS-1:0] STEP_V = PHASE_BITS'(STEP);
    localparam logic [PHASE_BITS-1:0] HALF_V = PHASE_BITS'(1) << (SHIFT - 1);
    localparam logic [PHASE_BITS-1:0] INIT_V = PHASE_BITS'(INIT_THETA);

    if ((CLK_RATE % STEP_RATE) != 0 || P < 2) begin : g_bad_rate
        $error("ship_rotate_ctrl: CLK_RATE/STEP_RATE must be an integer of at least 2");
    end
    if (SPRITE_BITS == 0 || SPRITE_BITS >= PHASE_BITS) begin : g_bad_sprite
        $error("ship_rotate_ctrl: SPRITE_BITS must be in 1..PHASE_BITS-1");
    end

    // Round to the nearest sprite; the add wraps so headings just below full circle give 0.
    function automatic logic [SPRITE_BITS-1:0] round_sprite(input logic [PHASE_BITS-1:0] th);
        logic [PHASE_BITS-1:0] r;
        r = th + HALF_V;
        return SPRITE_BITS'(r >> SHIFT);
    endfunction

    logic     db_left, db_right;
    rot_dir_t dir;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk_i  (clk),
        .rst_ni (resetN),
        .btn_i  (left_btn),
        .level_o(db_left)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk_i  (clk),
        .rst_ni (resetN),
        .btn_i  (right_btn),
        .level_o(db_right)
    );

    assign dir = decode_dir(db_left, db_right);

    rot_state_t            state_q, state_d;
    rot_dir_t              cur_dir_q, cur_dir_d, step_dir;
    logic [HW-1:0]         hold_q, hold_d;
    logic [PW-1:0]         per_q, per_d;
    logic [PHASE_BITS-1:0] theta_q, theta_d;
    logic                  strobe_q;
    logic [SPRITE_BITS-1:0] sprite_q;
    logic                  tick, per_clr, step;

    assign tick  = (per_q == PW'(P - 1));
    assign per_d = (per_clr || tick) ? '0 : per_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        hold_d    = hold_q;
        step_dir  = cur_dir_q;
        per_clr   = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && dir != NONE) begin
                    step      = 1'b1;
                    step_dir  = dir;
                    cur_dir_d = dir;
                    hold_d    = '0;
                    per_clr   = 1'b1;
                    state_d   = (HOLD_TICKS == 0) ? StRepeat : StDelay;
                end
            end
            StDelay: begin
                // A reversal also drops to idle; the new direction restarts from there.
                if (!enable || dir != cur_dir_q) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (hold_q == HW'(HOLD_TICKS - 1)) begin
                        step    = 1'b1;
                        state_d = StRepeat;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            StRepeat: begin
                if (!enable || dir != cur_dir_q) begin
                    state_d = StIdle;
                end else if (tick) begin
                    step = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        theta_d = theta_q;
        if (step) begin
            theta_d = (step_dir == LEFT) ? theta_q + STEP_V : theta_q - STEP_V;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= StIdle;
            cur_dir_q <= NONE;
            hold_q    <= '0;
            per_q     <= '0;
            theta_q   <= INIT_V;
            strobe_q  <= 1'b0;
            sprite_q  <= round_sprite(INIT_V);
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            hold_q    <= hold_d;
            per_q     <= per_d;
            theta_q   <= theta_d;
            strobe_q  <= step;
            sprite_q  <= round_sprite(theta_d);
        end
    end

    assign theta        = theta_q;
    assign theta_strobe = strobe_q;
    assign sprite_idx   = sprite_q;

endmodule

// File: tb/tb_ship_rotate_ctrl.sv
// Directed bench for ship_rotate_ctrl: expected heading steps are queued with their cycle
// and matched against every theta_strobe pulse.
module tb_ship_rotate_ctrl;

    localparam int unsigned PB = 10;
    localparam int unsigned SB = 4;

    logic          clk       = 1'b0;
    logic          resetN    = 1'b0;
    logic          left_btn  = 1'b0;
    logic          right_btn = 1'b0;
    logic          enable    = 1'b1;
    logic [PB-1:0] theta;
    logic          theta_strobe;
    logic [SB-1:0] sprite_idx;

    typedef struct {
        int th;
        int spr;
        int at;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   model_th = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ship_rotate_ctrl #(
        .CLK_RATE       (32),
        .STEP_RATE      (4),
        .PHASE_BITS     (PB),
        .STEP           (8),
        .HOLD_TICKS     (2),
        .DEBOUNCE_CYCLES(2),
        .SPRITE_BITS    (SB),
        .INIT_THETA     (0)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .left_btn    (left_btn),
        .right_btn   (right_btn),
        .enable      (enable),
        .theta       (theta),
        .theta_strobe(theta_strobe),
        .sprite_idx  (sprite_idx)
    );

    function automatic int spr_of(input int th);
        return ((th + 32) % 1024) / 64;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit left, input int at);
        model_th = left ? (model_th + 8) % 1024 : (model_th + 1016) % 1024;
        q.push_back('{model_th, spr_of(model_th), at});
    endtask

    // Short press: long enough for the first step, released before the hold delay expires.
    task automatic tap(input bit left);
        push(left, cyc + 5);
        if (left) left_btn = 1'b1;
        else      right_btn = 1'b1;
        wait_cyc(6);
        left_btn  = 1'b0;
        right_btn = 1'b0;
        wait_cyc(6);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (resetN && theta_strobe === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe: observed strobe at cycle %0d expected none", cyc);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("strobe_theta", 32'(theta), e.th);
                check("strobe_sprite", 32'(sprite_idx), e.spr);
                check("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int t0;

        // Reset values
        wait_cyc(3);
        check("rst_theta", 32'(theta), 0);
        check("rst_strobe", 32'(theta_strobe), 0);
        check("rst_sprite", 32'(sprite_idx), 0);
        resetN = 1'b1;
        wait_cyc(2);

        // Hold left: first step, hold delay, then auto-repeat
        t0 = cyc;
        left_btn = 1'b1;
        push(1, t0 + 5);
        push(1, t0 + 21);
        push(1, t0 + 29);
        push(1, t0 + 37);
        push(1, t0 + 45);
        wait_cyc(46);
        check("repeat_theta", 32'(theta), 40);
        check("repeat_queue_empty", q.size(), 0);

        // Asynchronous reset mid-repeat takes effect without a clock edge
        resetN = 1'b0;
        #1;
        check("async_rst_theta", 32'(theta), 0);
        check("async_rst_strobe", 32'(theta_strobe), 0);
        check("async_rst_sprite", 32'(sprite_idx), 0);
        left_btn = 1'b0;
        model_th = 0;
        q.delete();
        wait_cyc(2);
        resetN = 1'b1;
        wait_cyc(2);

        // Single right press wraps below zero, then left presses back through 24 to 88
        tap(0);
        check("wrap_theta", 32'(theta), 1016);
        check("wrap_sprite", 32'(sprite_idx), 0);
        for (int i = 0; i < 12; i++) tap(1);
        check("taps_theta", 32'(theta), 88);
        check("taps_sprite", 32'(sprite_idx), 1);

        // One-cycle glitch is filtered out
        left_btn = 1'b1;
        wait_cyc(1);
        left_btn = 1'b0;
        wait_cyc(20);
        check("glitch_theta", 32'(theta), 88);

        // Both held: no rotation; releasing right lets left take its first step
        left_btn  = 1'b1;
        right_btn = 1'b1;
        wait_cyc(20);
        check("both_theta", 32'(theta), 88);
        t0 = cyc;
        right_btn = 1'b0;
        push(1, t0 + 5);
        wait_cyc(6);
        left_btn = 1'b0;
        wait_cyc(8);
        check("release_right_theta", 32'(theta), 96);

        // Reversal while repeating: one idle cycle, then a fresh first step and delay
        t0 = cyc;
        left_btn = 1'b1;
        push(1, t0 + 5);
        push(1, t0 + 21);
        push(1, t0 + 29);
        wait_cyc(30);
        left_btn  = 1'b0;
        right_btn = 1'b1;
        push(0, t0 + 36);
        push(0, t0 + 52);
        push(0, t0 + 60);
        wait_cyc(31);
        right_btn = 1'b0;
        wait_cyc(12);
        check("reversal_theta", 32'(theta), 96);
        check("reversal_queue_empty", q.size(), 0);

        // Enable dropped mid-repeat freezes theta; re-enabling restarts from the first step
        resetN = 1'b0;
        wait_cyc(2);
        model_th = 0;
        resetN = 1'b1;
        wait_cyc(2);
        t0 = cyc;
        left_btn = 1'b1;
        push(1, t0 + 5);
        push(1, t0 + 21);
        push(1, t0 + 29);
        push(1, t0 + 37);
        push(1, t0 + 45);
        push(1, t0 + 53);
        wait_cyc(54);
        check("pre_disable_theta", 32'(theta), 48);
        enable = 1'b0;
        wait_cyc(16);
        check("disabled_theta", 32'(theta), 48);
        enable = 1'b1;
        push(1, t0 + 71);
        push(1, t0 + 87);
        wait_cyc(18);
        left_btn = 1'b0;
        wait_cyc(12);
        check("reenable_theta", 32'(theta), 64);
        check("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
